// File: rtl/query_loader_if.sv
// rtl/query_loader_if.sv - host word stream in, assembled query/k packet out to the search core
interface query_loader_if #(
    parameter int DIM     = 4,
    parameter int K_WIDTH = 16
);
    logic [31:0]        word_tdata;
    logic               word_tvalid;
    logic [31:0]        query [DIM];
    logic [K_WIDTH-1:0] k;
    logic               valid;
    logic               ready;

    // loader side: consumes the word stream, produces the packet
    modport slave (
        input  word_tdata, word_tvalid, ready,
        output query, k, valid
    );

    modport master (
        output word_tdata, word_tvalid, ready,
        input  query, k, valid
    );
endinterface

// File: rtl/query_loader.sv
// rtl/query_loader.sv - frames host words on a sync word and hands DIM query words plus a checked k to the core
module query_loader #(
    parameter int          DIM       = 4,
    parameter int          K_WIDTH   = 16,
    parameter int          K_MAX     = 5,
    parameter logic [31:0] SYNC_WORD = 32'hFFFF_FFFF
) (
    input  logic                        clk_100mhz,
    input  logic                        resetn,
    query_loader_if.slave               bus,
    output logic                        busy,
    output logic [$clog2(DIM+2)-1:0]    count,
    output logic                        err,
    output logic [1:0]                  err_code,
    output logic [15:0]                 pkt_count
);
    localparam int CW = $clog2(DIM + 2);

    typedef enum logic [1:0] {IDLE, COLLECT, GET_K, HOLD} state_t;

    state_t      state, state_next;
    logic [31:0] staging [DIM];

    logic is_sync, k_legal;
    logic clr_count, store_word, load_pkt, bad_k, drop_word, xfer;

    assign is_sync = (bus.word_tdata == SYNC_WORD);
    // range check on the full word so stray upper bits can never alias into a legal k
    assign k_legal = (bus.word_tdata != 32'd0) &&
                     (bus.word_tdata <= 32'(K_MAX)) &&
                     ((bus.word_tdata >> K_WIDTH) == 32'd0);

    always_ff @(posedge clk_100mhz or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        clr_count  = 1'b0;
        store_word = 1'b0;
        load_pkt   = 1'b0;
        bad_k      = 1'b0;
        drop_word  = 1'b0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.word_tvalid && is_sync) begin
                    state_next = COLLECT;
                    clr_count  = 1'b1;
                end
            end
            COLLECT: begin
                if (bus.word_tvalid) begin
                    if (is_sync) begin
                        clr_count = 1'b1;
                    end else begin
                        store_word = 1'b1;
                        if (count == CW'(DIM - 1)) state_next = GET_K;
                    end
                end
            end
            GET_K: begin
                if (bus.word_tvalid) begin
                    if (is_sync) begin
                        state_next = COLLECT;
                        clr_count  = 1'b1;
                    end else if (k_legal) begin
                        state_next = HOLD;
                        load_pkt   = 1'b1;
                    end else begin
                        state_next = IDLE;
                        bad_k      = 1'b1;
                    end
                end
            end
            HOLD: begin
                // the core owns the outputs here; anything the host sends is lost
                drop_word = bus.word_tvalid;
                if (bus.ready) begin
                    state_next = IDLE;
                    xfer       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DIM; i++) begin
                staging[i]   <= 32'd0;
                bus.query[i] <= 32'd0;
            end
            bus.k     <= '0;
            bus.valid <= 1'b0;
            busy      <= 1'b0;
            count     <= '0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            pkt_count <= 16'd0;
        end else begin
            busy <= (state_next != IDLE);

            if (state_next == IDLE || clr_count) count <= '0;
            else if (load_pkt)                   count <= CW'(DIM + 1);
            else if (store_word)                 count <= count + CW'(1);

            if (store_word) begin
                for (int i = 0; i < DIM; i++)
                    if (count == CW'(i)) staging[i] <= bus.word_tdata;
            end

            if (load_pkt) begin
                for (int i = 0; i < DIM; i++) bus.query[i] <= staging[i];
                bus.k     <= bus.word_tdata[K_WIDTH-1:0];
                bus.valid <= 1'b1;
            end else if (xfer) begin
                bus.valid <= 1'b0;
            end

            if (xfer) pkt_count <= pkt_count + 16'd1;

            err <= bad_k | drop_word;
            if (bad_k)          err_code <= 2'd1;
            else if (drop_word) err_code <= 2'd2;
        end
    end
endmodule

// File: tb/tb_query_loader.sv
// tb/tb_query_loader.sv - directed bench for query_loader
module tb_query_loader;
    localparam logic [31:0] SYNC = 32'hFFFF_FFFF;

    logic        clk_100mhz = 1'b0;
    logic        resetn;
    logic        busy;
    logic [2:0]  count;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] pkt_count;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;

    query_loader_if #(.DIM(4), .K_WIDTH(16)) bus ();

    query_loader #(.DIM(4), .K_WIDTH(16), .K_MAX(5), .SYNC_WORD(SYNC)) dut (
        .clk_100mhz (clk_100mhz),
        .resetn     (resetn),
        .bus        (bus),
        .busy       (busy),
        .count      (count),
        .err        (err),
        .err_code   (err_code),
        .pkt_count  (pkt_count)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    always begin
        @(posedge clk_100mhz);
        #1;
        if (err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] w);
        bus.word_tvalid = v;
        bus.word_tdata  = w;
        @(negedge clk_100mhz);
        bus.word_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] a, b, c, d, kk);
        cyc(1'b1, SYNC);
        cyc(1'b1, a);
        cyc(1'b1, b);
        cyc(1'b1, c);
        cyc(1'b1, d);
        cyc(1'b1, kk);
    endtask

    initial begin
        resetn          = 1'b0;
        bus.ready       = 1'b0;
        bus.word_tvalid = 1'b0;
        bus.word_tdata  = 32'd0;
        repeat (2) @(negedge clk_100mhz);
        resetn = 1'b1;
        @(negedge clk_100mhz);

        chk("rst_valid", bus.valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_q0", bus.query[0], 0);
        chk("rst_k", bus.k, 0);

        // basic packet, ready already high
        bus.ready = 1'b1;
        cyc(1'b1, 32'h55);
        chk("idle_ignore_busy", busy, 0);
        cyc(1'b1, SYNC);
        chk("t1_sync_busy", busy, 1);
        chk("t1_sync_count", count, 0);
        cyc(1'b1, 5);
        cyc(1'b1, 7);
        chk("t1_count2", count, 2);
        cyc(1'b1, 1);
        cyc(1'b1, 1);
        chk("t1_getk_count", count, 4);
        chk("t1_getk_valid", bus.valid, 0);
        cyc(1'b1, 4);
        chk("t1_valid", bus.valid, 1);
        chk("t1_q0", bus.query[0], 5);
        chk("t1_q1", bus.query[1], 7);
        chk("t1_q2", bus.query[2], 1);
        chk("t1_q3", bus.query[3], 1);
        chk("t1_k", bus.k, 4);
        chk("t1_hold_count", count, 5);
        cyc(1'b0, 0);
        chk("t1_after_valid", bus.valid, 0);
        chk("t1_pkt", pkt_count, 1);
        chk("t1_busy", busy, 0);
        chk("t1_count", count, 0);
        chk("t1_no_err", err_cnt, 0);

        // core stalls for ten cycles
        bus.ready = 1'b0;
        send_pkt(5, 7, 1, 1, 4);
        for (int i = 0; i < 10; i++) begin
            chk("t2_hold_valid", bus.valid, 1);
            chk("t2_hold_k", bus.k, 4);
            chk("t2_hold_q1", bus.query[1], 7);
            cyc(1'b0, 0);
        end
        bus.ready = 1'b1;
        chk("t2_last_valid", bus.valid, 1);
        chk("t2_last_q3", bus.query[3], 1);
        cyc(1'b0, 0);
        bus.ready = 1'b0;
        chk("t2_valid_drop", bus.valid, 0);
        chk("t2_pkt", pkt_count, 2);
        chk("t2_idle", busy, 0);

        // sync in the middle of a packet restarts it
        cyc(1'b1, SYNC);
        cyc(1'b1, 3);
        cyc(1'b1, 9);
        chk("t3_partial_count", count, 2);
        cyc(1'b1, SYNC);
        chk("t3_restart_count", count, 0);
        chk("t3_restart_busy", busy, 1);
        cyc(1'b1, 2);
        cyc(1'b1, 4);
        cyc(1'b1, 6);
        cyc(1'b1, 8);
        cyc(1'b1, 2);
        chk("t3_valid", bus.valid, 1);
        chk("t3_q0", bus.query[0], 2);
        chk("t3_q1", bus.query[1], 4);
        chk("t3_q2", bus.query[2], 6);
        chk("t3_q3", bus.query[3], 8);
        chk("t3_k", bus.k, 2);
        chk("t3_no_err", err_cnt, 0);
        bus.ready = 1'b1;
        cyc(1'b0, 0);
        bus.ready = 1'b0;
        chk("t3_pkt", pkt_count, 3);

        // illegal k values: zero, above K_MAX, stray upper bits
        send_pkt(1, 2, 3, 4, 0);
        chk("t4_k0_err", err, 1);
        chk("t4_k0_code", err_code, 1);
        chk("t4_k0_valid", bus.valid, 0);
        chk("t4_k0_busy", busy, 0);
        chk("t4_k0_count", count, 0);
        cyc(1'b0, 0);
        chk("t4_err_one_cycle", err, 0);
        chk("t4_code_held", err_code, 1);
        send_pkt(1, 2, 3, 4, 6);
        chk("t4_k6_err", err, 1);
        chk("t4_k6_valid", bus.valid, 0);
        send_pkt(1, 2, 3, 4, 32'h0001_0003);
        chk("t4_upper_err", err, 1);
        chk("t4_upper_code", err_code, 1);
        cyc(1'b0, 0);
        chk("t4_pkt", pkt_count, 3);
        chk("t4_k_unchanged", bus.k, 2);
        chk("t4_err_cnt", err_cnt, 3);

        // k at K_MAX, then words arriving during HOLD
        send_pkt(11, 22, 33, 44, 5);
        chk("t5_valid", bus.valid, 1);
        chk("t5_k", bus.k, 5);
        cyc(1'b1, 32'h12);
        chk("t5_drop_err", err, 1);
        chk("t5_drop_code", err_code, 2);
        chk("t5_drop_valid", bus.valid, 1);
        chk("t5_drop_q0", bus.query[0], 11);
        chk("t5_drop_count", count, 5);
        cyc(1'b1, SYNC);
        chk("t5_sync_drop_code", err_code, 2);
        chk("t5_sync_drop_busy", busy, 1);
        chk("t5_sync_drop_q3", bus.query[3], 44);
        bus.ready = 1'b1;
        cyc(1'b1, 32'h33);
        bus.ready = 1'b0;
        chk("t5_xfer_valid", bus.valid, 0);
        chk("t5_xfer_err", err, 1);
        chk("t5_xfer_pkt", pkt_count, 4);
        chk("t5_xfer_busy", busy, 0);
        cyc(1'b0, 0);
        chk("t5_err_low", err, 0);
        chk("t5_err_cnt", err_cnt, 6);

        // reset in the middle of a packet
        cyc(1'b1, SYNC);
        cyc(1'b1, 1);
        cyc(1'b1, 2);
        cyc(1'b1, 3);
        chk("t6_pre_count", count, 3);
        resetn = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_code", err_code, 0);
        chk("t6_rst_pkt", pkt_count, 0);
        chk("t6_rst_q0", bus.query[0], 0);
        chk("t6_rst_k", bus.k, 0);
        @(negedge clk_100mhz);
        chk("t6_rst_held_busy", busy, 0);
        resetn = 1'b1;
        @(negedge clk_100mhz);
        bus.ready = 1'b1;
        send_pkt(10, 20, 30, 40, 3);
        chk("t6_valid", bus.valid, 1);
        chk("t6_q0", bus.query[0], 10);
        chk("t6_q3", bus.query[3], 40);
        chk("t6_k", bus.k, 3);
        cyc(1'b0, 0);
        chk("t6_pkt", pkt_count, 1);
        chk("t6_valid_drop", bus.valid, 0);
        chk("t6_err_cnt", err_cnt, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
